conv_relu_pool: RTL and testbench
=================================

// Module: conv_relu_pool
// PURPOSE
//  Downstream of the conv write-back stage. Consumes its two result streams (port0/port1, paired output rows).
//  - Applies ReLU, right-shift requantisation and unsigned saturation.
//  - Applies 2x2 max-pooling across the two rows and two adjacent columns.
//  - Buffers pooled words in a small FIFO that drains over a valid/ready handshake.
//  - The write-back stage has no backpressure, so this block absorbs bursts and flags any loss.
// PARAMETERS
//  DATA_W      25  width of incoming conv sums (two's complement)
//  OUT_W       12  width of pooled output word (unsigned)
//  SHIFT        8  arithmetic right shift applied after ReLU
//  ROW_LEN     61  conv output columns per row (beats per row-pair)
//  FIFO_DEPTH   8  output FIFO entries, power of two
// PORTS
//  clk          in   1       clock, all logic on rising edge
//  rst_n        in   1       asynchronous active-low reset
//  clear        in   1       sync flush: FIFO, counters, sticky flags
//  port0        in   DATA_W  upper-row conv sum
//  port0_valid  in   1       port0 beat valid
//  port1        in   DATA_W  lower-row conv sum
//  port1_valid  in   1       port1 valid; 0 = single-row beat
//  out_data     out  OUT_W   FIFO head pooled word
//  out_valid    out  1       FIFO non-empty
//  out_ready    in   1       consumer accepts out_data this cycle
//  out_last     out  1       head word is last pooled word of its row-pair
//  overflow     out  1       sticky: pooled word dropped, FIFO full
//  proto_err    out  1       sticky: port1_valid seen with port0_valid=0
// BEHAVIOUR
//  Reset/clear:
//  - All registers 0.
//  - Outputs out_data=0, out_valid=0, out_last=0, overflow=0, proto_err=0.
//  - Reset is legal mid-row; the partial pool is discarded.
//  - clear has priority over every other update in its cycle.
//  Beat:
//  - A beat is a cycle with port0_valid=1. Beats with port0_valid=0 are ignored.
//  - If port1_valid=1 while port0_valid=0, the beat is still ignored and proto_err is set.
//  Stage 1 (registered), per lane:
//  - v<0 -> 0. Otherwise q = v>>>SHIFT, saturated to 2^OUT_W-1.
//  - An invalid port1 lane yields 0.
//  - The beat's valid is carried in s1_vld.
//  Stage 2 pool (from s1):
//  - col counter 0..ROW_LEN-1, held reg, phase EVEN/ODD.
//  - EVEN: held <= max(lane0, lane1); no push.
//  - ODD: push max(held, lane0, lane1) with last = (col == ROW_LEN-1).
//  - col == ROW_LEN-1 in EVEN phase (odd ROW_LEN): push max(lane0, lane1) alone with last=1.
//  - After col == ROW_LEN-1, col wraps to 0 and phase to EVEN.
//  - Words per row-pair: ceil(ROW_LEN/2), which is 31 for defaults.
//  Latency:
//  - The beat that triggers a push, sampled at edge k, is written to the FIFO at edge k+1.
//  - It is visible on out_data/out_valid after edge k+1 when the FIFO was empty.
//  FIFO:
//  - {data,last} entries; out_data/out_last come from the head; out_valid = (count != 0).
//  - pop = out_valid & out_ready.
//  - A push is accepted if count < FIFO_DEPTH, or if pop happens the same cycle. A full+push+pop cycle keeps count.
//  - Otherwise the word is dropped, overflow <= 1, and pointers/count are unchanged.
//  - Pointers wrap modulo FIFO_DEPTH.
//  - out_data stays stable while out_valid=1 and out_ready=0.
//  Sticky flags clear only on reset or clear.
// TESTING
//  - Quant: port0=0x0001234, port1=0x1FFFFFF (neg), two beats -> pooled 0x012 (4660>>8=18); neg lane gives 0.
//  - Saturate: port0=0x0FFFFFF for 2 beats -> out_data=0xFFF (OUT_W=12).
//  - Full row: 61 beats of incrementing values, out_ready=1 -> 31 words; word i = max of cols 2i,2i+1; word 30 = col 60 alone; out_last only on word 30.
//  - Single-row: port1_valid=0, port0 = 5,9,3,1,... -> words 9,3,...; lane1 contributes 0.
//  - Overflow: out_ready=0 over a 61-beat row -> exactly 8 words held, overflow=1; drain yields the first 8 words in order; clear -> overflow=0, out_valid=0.
//  - Full boundary: FIFO full, push and pop in the same cycle -> count stays 8, overflow stays 0.
//  - Async reset mid-row (col=20): out_valid=0 immediately; next row restarts at col 0.
//  - proto_err: port1_valid=1 with port0_valid=0 -> proto_err=1 and no push.

Source files
------------

// File: rtl/conv_relu_pool.sv
// conv_relu_pool: takes paired conv result rows and applies ReLU, requantisation
// and saturation, then 2x2 max-pooling. Pooled words are buffered in a small FIFO
// that drains over valid/ready. The upstream stage cannot be stalled, so a word
// that arrives while the FIFO is full is dropped and the loss is flagged (sticky).
//
// The pooling phase is just col[0]: even columns hold a value, odd columns push.
// col restarts at 0 on every row-pair, so the two always agree.
module conv_relu_pool #(
    parameter int DATA_W     = 25,
    parameter int OUT_W      = 12,
    parameter int SHIFT      = 8,
    parameter int ROW_LEN    = 61,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic [DATA_W-1:0] port0,
    input  logic              port0_valid,
    input  logic [DATA_W-1:0] port1,
    input  logic              port1_valid,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              overflow,
    output logic              proto_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int COL_W = $clog2(ROW_LEN);
    localparam logic [OUT_W-1:0] SAT = '1;
    localparam logic [COL_W-1:0] COL_END = COL_W'(ROW_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    // ReLU, then shift down, then clamp to the unsigned output range
    function automatic logic [OUT_W-1:0] quant(input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] sh;
        sh = v >> SHIFT;
        if (v[DATA_W-1])
            quant = '0;
        else if (sh > DATA_W'(SAT))
            quant = SAT;
        else
            quant = sh[OUT_W-1:0];
    endfunction

    function automatic logic [OUT_W-1:0] max2(input logic [OUT_W-1:0] a,
                                              input logic [OUT_W-1:0] b);
        max2 = (a > b) ? a : b;
    endfunction

    logic [OUT_W-1:0] s1_l0;
    logic [OUT_W-1:0] s1_l1;
    logic             s1_vld;

    logic [COL_W-1:0] col;
    logic [OUT_W-1:0] held;

    logic [OUT_W-1:0] m01;
    logic             at_end;
    logic             odd_col;
    logic             push;
    logic [OUT_W-1:0] push_data;

    logic [OUT_W:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [OUT_W:0]   head;
    logic             full;
    logic             pop;
    logic             push_ok;

    // Stage 1: quantise both lanes; a missing lower row contributes zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_l0  <= '0;
            s1_l1  <= '0;
            s1_vld <= 1'b0;
        end else if (clear) begin
            s1_l0  <= '0;
            s1_l1  <= '0;
            s1_vld <= 1'b0;
        end else begin
            s1_vld <= port0_valid;
            s1_l0  <= port0_valid ? quant(port0) : '0;
            s1_l1  <= (port0_valid && port1_valid) ? quant(port1) : '0;
        end
    end

    // Sticky flag for a lower-row beat without its upper row
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            proto_err <= 1'b0;
        else if (clear)
            proto_err <= 1'b0;
        else if (port1_valid && !port0_valid)
            proto_err <= 1'b1;
    end

    // Pool decision: odd columns and the trailing column of an odd-length row push
    always_comb begin
        m01       = max2(s1_l0, s1_l1);
        at_end    = (col == COL_END);
        odd_col   = col[0];
        push      = s1_vld && (odd_col || at_end);
        push_data = odd_col ? max2(held, m01) : m01;
    end

    // Stage 2: column tracking and the held half of the pooling window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col  <= '0;
            held <= '0;
        end else if (clear) begin
            col  <= '0;
            held <= '0;
        end else if (s1_vld) begin
            col <= at_end ? '0 : col + COL_W'(1);
            if (!odd_col)
                held <= m01;
        end
    end

    assign full    = (count == CNT_FULL);
    assign out_valid = (count != '0);
    assign pop     = out_valid && out_ready;
    assign push_ok = push && (!full || pop);
    assign head    = mem[rd_ptr];
    assign out_data = out_valid ? head[OUT_W-1:0] : '0;
    assign out_last = out_valid ? head[OUT_W] : 1'b0;

    // Output FIFO; a push into a full FIFO survives only if the head leaves this cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= {at_end, push_data};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (push_ok && !pop)
                count <= count + CNT_W'(1);
            else if (!push_ok && pop)
                count <= count - CNT_W'(1);
            if (push && !push_ok)
                overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_conv_relu_pool.sv
// Directed bench for conv_relu_pool: quantisation, pooling, row framing,
// FIFO overflow and full-boundary behaviour, reset and protocol errors.
module tb_conv_relu_pool;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic [24:0] port0;
    logic        port0_valid;
    logic [24:0] port1;
    logic        port1_valid;
    logic [11:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        overflow;
    logic        proto_err;

    int errors = 0;
    int checks = 0;
    logic [12:0] q[$];

    conv_relu_pool dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .port0       (port0),
        .port0_valid (port0_valid),
        .port1       (port1),
        .port1_valid (port1_valid),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .overflow    (overflow),
        .proto_err   (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every word the consumer accepts, sampled mid-cycle
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && out_valid && out_ready)
                q.push_back({out_last, out_data});
        end
    end

    task automatic drive(input logic [24:0] a, input logic av,
                         input logic [24:0] b, input logic bv);
        @(negedge clk);
        port0 = a;
        port0_valid = av;
        port1 = b;
        port1_valid = bv;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            port0_valid = 1'b0;
            port1_valid = 1'b0;
        end
    endtask

    task automatic do_clear();
        @(negedge clk);
        port0_valid = 1'b0;
        port1_valid = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear = 1'b0;
        port0 = '0;
        port1 = '0;
        port0_valid = 1'b0;
        port1_valid = 1'b0;
        out_ready = 1'b0;
        #23;
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++;
        if (out_data !== 12'h000) begin errors++; $display("FAIL reset_out_data: got %h want 000", out_data); end
        checks++;
        if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b want 0", out_last); end
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        checks++;
        if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto_err: got %b want 0", proto_err); end
    endtask

    task automatic test_quant();
        do_clear();
        out_ready = 1'b1;
        q.delete();
        drive(25'h0001234, 1'b1, 25'h1FFFFFF, 1'b1);
        drive(25'h0001234, 1'b1, 25'h1FFFFFF, 1'b1);
        idle(4);
        checks++;
        if (q.size() != 1) begin errors++; $display("FAIL quant_count: got %0d want 1", q.size()); end
        checks++;
        if (q.size() < 1 || q[0] !== 13'h0012) begin errors++; $display("FAIL quant_word: got %h want 0012", (q.size() > 0) ? q[0] : 13'h1FFF); end
        q.delete();
        drive(25'h1000000, 1'b1, 25'h1FFFF00, 1'b1);
        drive(25'h1800000, 1'b1, 25'h1000001, 1'b1);
        idle(4);
        checks++;
        if (q.size() != 1 || q[0] !== 13'h0000) begin errors++; $display("FAIL quant_negative: got size %0d word %h want size 1 word 0000", q.size(), (q.size() > 0) ? q[0] : 13'h1FFF); end
    endtask

    task automatic test_saturate();
        do_clear();
        out_ready = 1'b1;
        q.delete();
        drive(25'h0FFFFFF, 1'b1, 25'h0, 1'b0);
        drive(25'h0FFFFFF, 1'b1, 25'h0, 1'b0);
        drive(25'h0, 1'b1, 25'h0FFFFFF, 1'b1);
        drive(25'h0, 1'b1, 25'h0FFFFFF, 1'b1);
        idle(4);
        checks++;
        if (q.size() != 2) begin errors++; $display("FAIL sat_count: got %0d want 2", q.size()); end
        checks++;
        if (q.size() < 1 || q[0] !== 13'h0FFF) begin errors++; $display("FAIL sat_lane0: got %h want 0fff", (q.size() > 0) ? q[0] : 13'h1FFF); end
        checks++;
        if (q.size() < 2 || q[1] !== 13'h0FFF) begin errors++; $display("FAIL sat_lane1: got %h want 0fff", (q.size() > 1) ? q[1] : 13'h1FFF); end
    endtask

    task automatic test_full_row();
        logic [12:0] exp;
        do_clear();
        out_ready = 1'b1;
        q.delete();
        for (int c = 0; c < 61; c++)
            drive(25'(c << 8), 1'b1, 25'((c + 3) << 8), 1'b1);
        idle(4);
        checks++;
        if (q.size() != 31) begin errors++; $display("FAIL row_count: got %0d want 31", q.size()); end
        for (int i = 0; i < 31 && i < q.size(); i++) begin
            exp = (i == 30) ? {1'b1, 12'd63} : {1'b0, 12'(2 * i + 4)};
            checks++;
            if (q[i] !== exp) begin errors++; $display("FAIL row_word%0d: got %h want %h", i, q[i], exp); end
        end
    endtask

    task automatic test_single_row();
        do_clear();
        out_ready = 1'b1;
        q.delete();
        drive(25'(5 << 8), 1'b1, 25'h0FFFFFF, 1'b0);
        drive(25'(9 << 8), 1'b1, 25'h0FFFFFF, 1'b0);
        drive(25'(3 << 8), 1'b1, 25'h0FFFFFF, 1'b0);
        drive(25'(1 << 8), 1'b1, 25'h0FFFFFF, 1'b0);
        idle(4);
        checks++;
        if (q.size() != 2) begin errors++; $display("FAIL single_count: got %0d want 2", q.size()); end
        checks++;
        if (q.size() < 1 || q[0] !== 13'd9) begin errors++; $display("FAIL single_word0: got %h want 0009", (q.size() > 0) ? q[0] : 13'h1FFF); end
        checks++;
        if (q.size() < 2 || q[1] !== 13'd3) begin errors++; $display("FAIL single_word1: got %h want 0003", (q.size() > 1) ? q[1] : 13'h1FFF); end
    endtask

    task automatic test_overflow();
        do_clear();
        out_ready = 1'b0;
        q.delete();
        for (int c = 0; c < 61; c++)
            drive(25'(c << 8), 1'b1, 25'h0, 1'b0);
        idle(4);
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 12'd1) begin errors++; $display("FAIL ovf_head: got valid %b data %h want 1 001", out_valid, out_data); end
        idle(3);
        checks++;
        if (out_data !== 12'd1) begin errors++; $display("FAIL ovf_stable: got %h want 001", out_data); end
        out_ready = 1'b1;
        idle(12);
        out_ready = 1'b0;
        checks++;
        if (q.size() != 8) begin errors++; $display("FAIL ovf_drain_count: got %0d want 8", q.size()); end
        for (int i = 0; i < 8 && i < q.size(); i++) begin
            checks++;
            if (q[i] !== {1'b0, 12'(2 * i + 1)}) begin errors++; $display("FAIL ovf_word%0d: got %h want %h", i, q[i], {1'b0, 12'(2 * i + 1)}); end
        end
        checks++;
        if (out_valid !== 1'b0 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_after_drain: got valid %b overflow %b want 0 1", out_valid, overflow); end
        do_clear();
        checks++;
        if (overflow !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL ovf_clear: got overflow %b valid %b want 0 0", overflow, out_valid); end
    endtask

    task automatic test_full_boundary();
        do_clear();
        out_ready = 1'b0;
        q.delete();
        for (int c = 0; c < 16; c++)
            drive(25'(c << 8), 1'b1, 25'h0, 1'b0);
        idle(3);
        checks++;
        if (overflow !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL full_fill: got overflow %b valid %b want 0 1", overflow, out_valid); end
        drive(25'(16 << 8), 1'b1, 25'h0, 1'b0);
        drive(25'(17 << 8), 1'b1, 25'h0, 1'b0);
        @(negedge clk);
        port0_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL full_push_pop_overflow: got %b want 0", overflow); end
        out_ready = 1'b1;
        idle(12);
        out_ready = 1'b0;
        checks++;
        if (q.size() != 9) begin errors++; $display("FAIL full_drain_count: got %0d want 9", q.size()); end
        checks++;
        if (q.size() < 9 || q[8] !== 13'd17) begin errors++; $display("FAIL full_last_word: got %h want 0011", (q.size() > 8) ? q[8] : 13'h1FFF); end
        checks++;
        if (q.size() < 1 || q[0] !== 13'd1) begin errors++; $display("FAIL full_first_word: got %h want 0001", (q.size() > 0) ? q[0] : 13'h1FFF); end
    endtask

    task automatic test_async_reset();
        int nlast;
        do_clear();
        out_ready = 1'b0;
        q.delete();
        for (int c = 0; c < 21; c++)
            drive(25'(c << 8), 1'b1, 25'h0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 12'h000) begin errors++; $display("FAIL rst_mid_outputs: got valid %b data %h want 0 000", out_valid, out_data); end
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL rst_mid_overflow: got %b want 0", overflow); end
        port0_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        q.delete();
        for (int c = 0; c < 61; c++)
            drive(25'(c << 8), 1'b1, 25'h0, 1'b0);
        idle(4);
        checks++;
        if (q.size() != 31) begin errors++; $display("FAIL rst_row_count: got %0d want 31", q.size()); end
        nlast = 0;
        foreach (q[i]) if (q[i][12]) nlast++;
        checks++;
        if (nlast != 1) begin errors++; $display("FAIL rst_row_last_count: got %0d want 1", nlast); end
        checks++;
        if (q.size() < 31 || q[30] !== {1'b1, 12'd60}) begin errors++; $display("FAIL rst_row_word30: got %h want 103c", (q.size() > 30) ? q[30] : 13'h1FFF); end
        checks++;
        if (q.size() < 1 || q[0] !== 13'd1) begin errors++; $display("FAIL rst_row_word0: got %h want 0001", (q.size() > 0) ? q[0] : 13'h1FFF); end
    endtask

    task automatic test_proto_err();
        do_clear();
        out_ready = 1'b1;
        q.delete();
        drive(25'(7 << 8), 1'b1, 25'h0, 1'b0);
        drive(25'h0, 1'b0, 25'(9 << 8), 1'b1);
        idle(4);
        checks++;
        if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_flag: got %b want 1", proto_err); end
        checks++;
        if (q.size() != 0 || out_valid !== 1'b0) begin errors++; $display("FAIL proto_no_push: got %0d words valid %b want 0 0", q.size(), out_valid); end
        drive(25'(1 << 8), 1'b1, 25'h0, 1'b0);
        idle(4);
        checks++;
        if (q.size() != 1 || q[0] !== 13'd7) begin errors++; $display("FAIL proto_pairing: got size %0d word %h want 1 0007", q.size(), (q.size() > 0) ? q[0] : 13'h1FFF); end
        do_clear();
        checks++;
        if (proto_err !== 1'b0) begin errors++; $display("FAIL proto_clear: got %b want 0", proto_err); end
    endtask

    initial begin
        test_reset();
        test_quant();
        test_saturate();
        test_full_row();
        test_single_row();
        test_overflow();
        test_full_boundary();
        test_async_reset();
        test_proto_err();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
